ramp_seq: RTL and testbench

Sequencer for the Ramp pattern datapath: owns `ramp_enb`, `delta` and `Y` and produces timed staircase sweeps from 0 towards 4095 without ever letting the 12-bit ramp output wrap. It paces one `delta` pulse every `period` clocks, dwells at the top value and then finishes or restarts. It sits between the pattern-control registers and one Ramp instance, and keeps a shadow copy of the ramp value for status readback.

---
 rtl/ramp_seq.sv | 200 ++++++++++++++++++++
 tb/tb_ramp_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_seq.sv
// ramp_seq: sequencer for one Ramp pattern datapath.
// Produces timed staircase sweeps from 0 towards 4095 and never lets the 12-bit ramp wrap.
// One delta pulse is issued every `period` clocks. The sequencer then dwells at the top value
// and finishes, or restarts when repeat mode is in use.
//
// Ports
//   i_clk        master clock
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle sweep request, honoured only in IDLE
//   i_abort      stop any sweep; wins over i_start
//   i_y_sel[1:0] step select 00=0, 01=1, 10=16, 11=1290 (latched at start)
//   i_period     clocks between delta pulses, 0 treated as 1 (latched at start)
//   i_dwell      clocks held at the top value, 0 treated as 1 (latched at start)
//   i_repeat     sawtooth mode (latched at start, only with RAMP_SEQ_REPEAT_EN)
//   o_ramp_enb   Ramp enable
//   o_delta      Ramp delta, single-cycle pulses
//   o_y[1:0]     Ramp Y, the latched step select
//   o_busy       high in ARM, RUN and HOLD
//   o_done       one-cycle pulse at the end of a sweep
//   o_shadow     mirror of the Ramp output value
//   o_step_cnt   delta pulses issued in the current sweep
//
// Build option: define RAMP_SEQ_REPEAT_EN to build the repeat (sawtooth) logic.
// When it is undefined, i_repeat is ignored and every sweep ends in DONE.
module ramp_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [1:0]  i_y_sel,
    input  logic [15:0] i_period,
    input  logic [15:0] i_dwell,
    input  logic        i_repeat,
    output logic        o_ramp_enb,
    output logic        o_delta,
    output logic [1:0]  o_y,
    output logic        o_busy,
    output logic        o_done,
    output logic [11:0] o_shadow,
    output logic [11:0] o_step_cnt
);

    typedef enum logic [2:0] {StIdle, StArm, StRun, StHold, StDone} state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_timer, w_timer_d;
    logic [15:0] r_period, r_dwell;
    logic [1:0]  r_y;
    logic [11:0] r_shadow, w_shadow_d;
    logic [11:0] r_step_cnt, w_step_cnt_d;
    logic        r_delta, w_delta_d;
    logic        r_ramp_enb, w_ramp_enb_d;
    logic        r_busy, w_busy_d;
    logic        r_done, w_done_d;
    logic [11:0] w_dy;
    logic [12:0] w_sum;
    logic        w_launch;
    logic        w_repeat_en;

    assign w_launch = (r_state == StIdle) && i_start && !i_abort;

`ifdef RAMP_SEQ_REPEAT_EN
    logic r_repeat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_repeat <= 1'b0;
        end else if (w_launch) begin
            r_repeat <= i_repeat;
        end
    end

    assign w_repeat_en = r_repeat;
`else
    logic w_unused_repeat;

    assign w_unused_repeat = i_repeat;
    assign w_repeat_en     = 1'b0;
`endif

    always_comb begin
        w_dy = 12'd0;
        unique case (r_y)
            2'b00: w_dy = 12'd0;
            2'b01: w_dy = 12'd1;
            2'b10: w_dy = 12'd16;
            2'b11: w_dy = 12'd1290;
            default: w_dy = 12'd0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_timer <= 16'd0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
        end
    end

    // Next-state logic. A RUN timer expiry either turns into a pulse or into HOLD. That choice
    // was made one cycle earlier and is already visible as r_delta.
    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        if (r_state != StIdle && i_abort) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_launch) w_state_d = StArm;
                end
                StArm: begin
                    w_state_d = StRun;
                    w_timer_d = r_period;
                end
                StRun: begin
                    if (r_timer == 16'd1) begin
                        if (r_delta) begin
                            w_timer_d = r_period;
                        end else begin
                            w_state_d = StHold;
                            w_timer_d = r_dwell;
                        end
                    end else begin
                        w_timer_d = r_timer - 16'd1;
                    end
                end
                StHold: begin
                    if (r_timer == 16'd1) begin
                        w_state_d = w_repeat_en ? StArm : StDone;
                    end else begin
                        w_timer_d = r_timer - 16'd1;
                    end
                end
                StDone: w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Output next values. The outputs are registered, so they are computed from the next state.
    // The shadow register follows the Ramp: it is cleared when ARM is entered and it advances
    // on the edge that ends a delta cycle, even if that edge also aborts the sweep.
    always_comb begin
        w_shadow_d   = r_shadow;
        w_step_cnt_d = r_step_cnt;
        if (w_state_d == StArm) begin
            w_shadow_d   = 12'd0;
            w_step_cnt_d = 12'd0;
        end else if (r_delta) begin
            w_shadow_d   = r_shadow + w_dy;
            w_step_cnt_d = r_step_cnt + 12'd1;
        end
        // 13-bit headroom check, so the ramp can never be driven past 4095
        w_sum        = {1'b0, w_shadow_d} + {1'b0, w_dy};
        w_delta_d    = (w_state_d == StRun) && (w_timer_d == 16'd1) && (w_dy != 12'd0) &&
                       (w_sum <= 13'd4095);
        w_ramp_enb_d = (w_state_d == StRun) || (w_state_d == StHold) || (w_state_d == StDone);
        w_busy_d     = (w_state_d == StArm) || (w_state_d == StRun) || (w_state_d == StHold);
        w_done_d     = (w_state_d == StDone);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period   <= 16'd0;
            r_dwell    <= 16'd0;
            r_y        <= 2'b00;
            r_shadow   <= 12'd0;
            r_step_cnt <= 12'd0;
            r_delta    <= 1'b0;
            r_ramp_enb <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_launch) begin
                r_period <= (i_period == 16'd0) ? 16'd1 : i_period;
                r_dwell  <= (i_dwell == 16'd0) ? 16'd1 : i_dwell;
                r_y      <= i_y_sel;
            end
            r_shadow   <= w_shadow_d;
            r_step_cnt <= w_step_cnt_d;
            r_delta    <= w_delta_d;
            r_ramp_enb <= w_ramp_enb_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign o_ramp_enb = r_ramp_enb;
    assign o_delta    = r_delta;
    assign o_y        = r_y;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_shadow   = r_shadow;
    assign o_step_cnt = r_step_cnt;

endmodule

// File: tb/tb_ramp_seq.sv
// Self-checking bench for ramp_seq: uses a timeline model plus directed and random sweeps.
module tb_ramp_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  y_sel;
    logic [15:0] period;
    logic [15:0] dwell;
    logic        rep_i;
    logic        o_ramp_enb;
    logic        o_delta;
    logic [1:0]  o_y;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_shadow;
    logic [11:0] o_step_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ramp_seq dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_y_sel    (y_sel),
        .i_period   (period),
        .i_dwell    (dwell),
        .i_repeat   (rep_i),
        .o_ramp_enb (o_ramp_enb),
        .o_delta    (o_delta),
        .o_y        (o_y),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_shadow   (o_shadow),
        .o_step_cnt (o_step_cnt)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Timeline model. A sweep is fixed by the cycle `a` of its ARM, the pacing P, the dwell D,
    // the step dY and its step count N = 4095/dY. Relative to `a`, pulses fall at k*P for
    // k = 1..N. RUN covers 1..(N+1)*P, HOLD covers the next D cycles, and the next cycle is
    // DONE, or the next ARM in repeat mode.
    bit m_active = 0;
    bit m_rep    = 0;
    int m_a = 0, m_p = 1, m_d = 1, m_dy = 0, m_n = 0, m_y = 0, m_sh = 0, m_st = 0;

    always @(negedge clk) begin
        int o, lrun, len, k;
        int e_enb, e_delta, e_busy, e_done, e_sh, e_st, e_y;
        e_enb = 0; e_delta = 0; e_busy = 0; e_done = 0; e_sh = m_sh; e_st = m_st; e_y = m_y;
        if (!rst_n) begin
            e_sh = 0; e_st = 0; e_y = 0;
        end else if (m_active) begin
            lrun = (m_n + 1) * m_p;
            len  = lrun + m_d + 1;
            o    = cyc - m_a;
            if (m_rep) o = o % len;
            if (o == 0) begin
                e_busy = 1; e_sh = 0; e_st = 0;
            end else if (o <= lrun) begin
                e_enb = 1; e_busy = 1;
                k = (o - 1) / m_p;
                if (k > m_n) k = m_n;
                e_st = k; e_sh = k * m_dy;
                e_delta = ((o % m_p) == 0 && (o / m_p) <= m_n) ? 1 : 0;
            end else if (o <= lrun + m_d) begin
                e_enb = 1; e_busy = 1; e_st = m_n; e_sh = m_n * m_dy;
            end else begin
                e_enb = 1; e_done = 1; e_st = m_n; e_sh = m_n * m_dy;
            end
        end
        chk("ramp_enb", int'(o_ramp_enb), e_enb);
        chk("delta", int'(o_delta), e_delta);
        chk("busy", int'(o_busy), e_busy);
        chk("done", int'(o_done), e_done);
        chk("shadow", int'(o_shadow), e_sh);
        chk("step_cnt", int'(o_step_cnt), e_st);
        chk("y", int'(o_y), e_y);
        // advance the model with the inputs the next edge will sample
        if (!rst_n) begin
            m_active = 0; m_y = 0; m_sh = 0; m_st = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1;
                m_a  = cyc + 1;
                m_p  = (period == 16'd0) ? 1 : int'(period);
                m_d  = (dwell == 16'd0) ? 1 : int'(dwell);
                m_y  = int'(y_sel);
                m_dy = (y_sel == 2'b00) ? 0 : (y_sel == 2'b01) ? 1 : (y_sel == 2'b10) ? 16 : 1290;
                m_n  = (m_dy == 0) ? 0 : 4095 / m_dy;
`ifdef RAMP_SEQ_REPEAT_EN
                m_rep = rep_i;
`else
                m_rep = 0;
`endif
            end
        end else if (abort) begin
            m_active = 0;
            m_sh = e_sh + (e_delta != 0 ? m_dy : 0);
            m_st = e_st + e_delta;
        end else if (e_done != 0) begin
            m_active = 0; m_sh = e_sh; m_st = e_st;
        end
        cyc++;
    end

    localparam int Budget = 5000;

    // Launch one sweep at posedge+1 and follow it until the DUT is idle again.
    // Abort fires once np reaches ab_np or at cycle ab_cyc, and start is raised with it;
    // that start must be ignored. rnd_start adds stray start pulses while the DUT is busy.
    task automatic run(input logic [1:0] y, input int p, input int d, input bit rep,
                       input int ab_np, input int ab_cyc, input bit rnd_start,
                       output int np, output int first, output int last,
                       output int nd, output int done_at);
        bit ab_done, ab_now, fin, was_busy;
        np = 0; first = -1; last = -1; nd = 0; done_at = -1;
        ab_done = 0; fin = 0;
        y_sel = y; period = p[15:0]; dwell = d[15:0]; rep_i = rep;
        start = 1'b1; abort = 1'b0;
        for (int k = 0; k < Budget && !fin; k++) begin
            @(negedge clk); #1;
            if (o_delta) begin
                np++;
                if (first < 0) first = k;
                last = k;
            end
            if (o_done) begin
                nd++;
                done_at = k;
            end
            was_busy = o_busy;
            if (k > 0 && !o_busy && !o_done) fin = 1;
            @(posedge clk); #1;
            ab_now = !ab_done && ((ab_np > 0 && np >= ab_np) || (ab_cyc > 0 && k + 1 >= ab_cyc));
            if (ab_now) ab_done = 1;
            abort = ab_now;
            start = was_busy && (ab_now || (rnd_start && !ab_done && ($urandom % 6) == 0));
        end
        start = 1'b0; abort = 1'b0;
        if (!fin) chk("sweep_timeout", 1, 0);
    endtask

    int np, first, last, nd, done_at;

    initial begin
        start = 0; abort = 0; y_sel = 0; period = 0; dwell = 0; rep_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // dY=16, P=1: 255 pulses on cycles 2..256, top 4080, DONE on cycle 259
        run(2'b10, 1, 1, 0, 0, 0, 0, np, first, last, nd, done_at);
        chk("A_pulses", np, 255);
        chk("A_first", first, 2);
        chk("A_last", last, 256);
        chk("A_done_cnt", nd, 1);
        chk("A_done_at", done_at, 259);
        chk("A_shadow", int'(o_shadow), 4080);
        chk("A_step", int'(o_step_cnt), 255);

        // dY=1290, P=4, D=3: pulses 5, 9, 13; 3 HOLD cycles; DONE on cycle 21
        run(2'b11, 4, 3, 0, 0, 0, 0, np, first, last, nd, done_at);
        chk("B_pulses", np, 3);
        chk("B_first", first, 5);
        chk("B_last", last, 13);
        chk("B_done_at", done_at, 21);
        chk("B_shadow", int'(o_shadow), 3870);

        // dY=0, P=2, D=2: no pulses, but DONE still comes, on cycle 6
        run(2'b00, 2, 2, 0, 0, 0, 0, np, first, last, nd, done_at);
        chk("C_pulses", np, 0);
        chk("C_done_cnt", nd, 1);
        chk("C_done_at", done_at, 6);
        chk("C_shadow", int'(o_shadow), 0);

        // dY=1, P=3: abort (with a simultaneous start) after the 10th pulse
        run(2'b01, 3, 1, 0, 10, 0, 0, np, first, last, nd, done_at);
        chk("D_pulses", np, 10);
        chk("D_done_cnt", nd, 0);
        chk("D_shadow", int'(o_shadow), 10);
        chk("D_step", int'(o_step_cnt), 10);
        chk("D_enb", int'(o_ramp_enb), 0);

        // start and abort in the same IDLE cycle: stay idle, Y unchanged
        y_sel = 2'b11; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk); #1;
        chk("E_busy", int'(o_busy), 0);
        chk("E_y", int'(o_y), 1);
        @(posedge clk); #1;

        // Repeat request with dY=1290, P=2, D=1
`ifdef RAMP_SEQ_REPEAT_EN
        run(2'b11, 2, 1, 1, 7, 0, 0, np, first, last, nd, done_at);
        chk("F_pulses", np, 7);
        chk("F_done_cnt", nd, 0);
        chk("F_step", int'(o_step_cnt), 1);
        chk("F_last", last, 23);
`else
        run(2'b11, 2, 1, 1, 0, 0, 0, np, first, last, nd, done_at);
        chk("F_pulses", np, 3);
        chk("F_done_cnt", nd, 1);
        chk("F_done_at", done_at, 11);
        chk("F_step", int'(o_step_cnt), 3);
`endif

        // Asynchronous reset in the middle of a dY=16, P=5 sweep
        y_sel = 2'b10; period = 16'd5; dwell = 16'd1; rep_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #2;
        chk("R_enb", int'(o_ramp_enb), 0);
        chk("R_shadow", int'(o_shadow), 0);
        chk("R_step", int'(o_step_cnt), 0);
        chk("R_busy", int'(o_busy), 0);
        chk("R_y", int'(o_y), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run(2'b01, 7, 2, 0, 2, 0, 0, np, first, last, nd, done_at);
        chk("R_first", first, 8);

        // Random sweeps; long or endless sweeps are always cut short by an abort
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ry;
            int rp, rd, ra_np, ra_cyc;
            bit rr;
            ry     = 2'($urandom % 4);
            rp     = int'($urandom % 7);
            rd     = int'($urandom % 5);
            rr     = 1'($urandom % 2);
            ra_np  = (($urandom % 3) == 0) ? 1 + int'($urandom % 6) : 0;
            ra_cyc = (($urandom % 2) == 0) ? 2 + int'($urandom % 120) : 0;
            if ((ry == 2'b01 || rr) && ra_cyc == 0) ra_cyc = 2 + int'($urandom % 200);
            run(ry, rp, rd, rr, ra_np, ra_cyc, 1, np, first, last, nd, done_at);
            repeat (int'($urandom % 3)) @(posedge clk);
            #1;
        end

        @(negedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
